// File: rtl/wb_accum_array.sv
// Wishbone bank of CHANNELS signed add/sub accumulators with LA preload.
// Define SATURATE_EN to clamp add/sub at the signed limits instead of wrapping.
module wb_accum_array #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic                 la_load_en,
  input  logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] la_load_ch,
  input  logic [WIDTH-1:0]     la_load_data,
  output logic [WIDTH-1:0]     acc_sel_o,
  output logic                 irq_o
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {M{1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {M{1'b0}}};

  logic [WIDTH-1:0]    r_acc [CHANNELS];
  logic [1:0]          r_op;
  logic [3:0]          r_ch;
  logic                r_irq_en;
  logic [CHANNELS-1:0] r_status;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_irq;

  logic                w_fire, w_wr, w_rd;
  logic [4:0]          w_idx, w_dir_n;
  logic [31:0]         w_be, w_dir_new, w_rdata;
  logic                w_ch_ok, w_dir_ok;
  logic                w_op_go, w_dir_go, w_ovf;
  logic [WIDTH-1:0]    w_a, w_b, w_sum, w_res, w_dir_old;
  logic [CHANNELS-1:0] w_set, w_clr;
  logic                w_unused;

  assign w_fire = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr   = w_fire & wbs_we_i;
  assign w_rd   = w_fire & ~wbs_we_i;
  assign w_idx  = wbs_adr_i[6:2];
  assign w_be   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_unused = ^{wbs_adr_i[31:7], wbs_adr_i[1:0]};

  assign w_ch_ok  = {1'b0, r_ch} < 5'(CHANNELS);
  assign w_dir_ok = (w_idx >= 5'd4) && (w_idx < 5'(4 + CHANNELS));
  assign w_dir_n  = w_idx - 5'd4;
  assign w_op_go  = w_wr && (w_idx == 5'd1) &&
                    (wbs_sel_i == 4'hF) && w_ch_ok;
  assign w_dir_go = w_wr && w_dir_ok;

  always_comb begin
    w_a       = '0;
    w_dir_old = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_ch == 4'(i))    w_a = r_acc[i];
      if (w_dir_n == 5'(i)) w_dir_old = r_acc[i];
    end
  end

  assign w_dir_new = (32'(w_dir_old) & ~w_be) | (wbs_dat_i & w_be);
  assign w_b       = wbs_dat_i[WIDTH-1:0];
  assign w_sum     = (r_op == 2'd0) ? w_a + w_b : w_a - w_b;

  always_comb begin
    w_ovf = 1'b0;
    w_res = w_sum;
    unique case (r_op)
      2'd0: w_ovf = (w_a[M] == w_b[M]) && (w_sum[M] != w_a[M]);
      2'd1: w_ovf = (w_a[M] != w_b[M]) && (w_sum[M] != w_a[M]);
      2'd2: w_res = w_b;
      2'd3: w_res = '0;
    endcase
`ifdef SATURATE_EN
    // overflow direction always follows the sign of the accumulator
    if (w_ovf) w_res = w_a[M] ? SMIN : SMAX;
`endif
  end

  always_comb begin
    w_set = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_set[i] = w_op_go && w_ovf && (r_ch == 4'(i));
  end

  assign w_clr = (w_wr && w_idx == 5'd3) ?
                 (wbs_dat_i[CHANNELS-1:0] & w_be[CHANNELS-1:0]) : '0;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_idx == 5'd0): w_rdata = {23'b0, r_irq_en, r_ch, 2'b0, r_op};
      (w_idx == 5'd2): w_rdata = w_ch_ok ? 32'($signed(w_a)) : '0;
      (w_idx == 5'd3): w_rdata = 32'(r_status);
      w_dir_ok:        w_rdata = 32'($signed(w_dir_old));
      default:         w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_ch     <= '0;
      r_irq_en <= 1'b0;
      r_status <= '0;
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
    end else begin
      r_ack    <= w_fire;
      r_irq    <= r_irq_en & (|r_status);
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_rd) r_dat <= w_rdata;
      if (w_wr && w_idx == 5'd0) begin
        if (wbs_sel_i[0]) begin
          r_op <= wbs_dat_i[1:0];
          r_ch <= wbs_dat_i[7:4];
        end
        if (wbs_sel_i[1]) r_irq_en <= wbs_dat_i[8];
      end
      // WB commits win over an LA preload to the same channel
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_op_go && r_ch == 4'(i))
          r_acc[i] <= w_res;
        else if (w_dir_go && w_dir_n == 5'(i))
          r_acc[i] <= w_dir_new[WIDTH-1:0];
        else if (la_load_en && la_load_ch == CH_W'(i))
          r_acc[i] <= la_load_data;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;
  assign acc_sel_o = w_a;

endmodule

// File: tb/tb_wb_accum_array.sv
// Directed bench for wb_accum_array (default WIDTH=32, CHANNELS=4).
// Expected values are hand-computed; SATURATE_EN selects the clamp result.
module tb_wb_accum_array;
  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        la_load_en;
  logic [1:0]  la_load_ch;
  logic [31:0] la_load_data;
  logic [31:0] acc_sel_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  wb_accum_array dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_load_en(la_load_en), .la_load_ch(la_load_ch),
    .la_load_data(la_load_data),
    .acc_sel_o(acc_sel_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic la_en, input logic [1:0] la_ch,
                      input logic [31:0] la_d,
                      output logic [31:0] q);
    int n;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    la_load_en = la_en; la_load_ch = la_ch; la_load_data = la_d;
    @(negedge clk);
    la_load_en = 1'b0;
    n = 0;
    while (wbs_ack_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL ack_timeout adr=%h got=none want=ack", adr);
    end
    q = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, wbs_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] q;
    xfer(1'b1, adr, dat, sel, 1'b0, 2'd0, 32'd0, q);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] adr,
                       input logic [31:0] exp);
    logic [31:0] q;
    xfer(1'b0, adr, 32'd0, 4'hF, 1'b0, 2'd0, 32'd0, q);
    chk(tag, q, exp);
  endtask

  initial begin
    reset = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    la_load_en = 0; la_load_ch = 0; la_load_data = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_accsel", acc_sel_o, 32'd0);
    for (int a = 0; a < 8; a++)
      rdchk("rst_reg", 32'(a * 4), 32'd0);

    wr(32'h00, 32'h20, 4'hF);
    wr(32'h04, 32'd5, 4'hF);
    wr(32'h04, 32'd7, 4'hF);
    rdchk("add_result", 32'h08, 32'd12);
    chk("add_accsel", acc_sel_o, 32'd12);
    rdchk("add_acc2", 32'h18, 32'd12);
    rdchk("add_acc0", 32'h10, 32'd0);
    rdchk("add_acc1", 32'h14, 32'd0);
    rdchk("add_acc3", 32'h1C, 32'd0);

    @(negedge clk);
    la_load_en = 1'b1; la_load_ch = 2'd1; la_load_data = 32'h7FFF_FFFF;
    @(negedge clk);
    la_load_en = 1'b0;
    wr(32'h00, 32'h110, 4'hF);
    rdchk("la_acc1", 32'h08, 32'h7FFF_FFFF);
    wr(32'h04, 32'd1, 4'hF);
`ifdef SATURATE_EN
    rdchk("ovf_result", 32'h08, 32'h7FFF_FFFF);
`else
    rdchk("ovf_result", 32'h08, 32'h8000_0000);
`endif
    rdchk("ovf_status", 32'h0C, 32'h2);
    chk("ovf_irq", {31'b0, irq_o}, 32'd1);
    wr(32'h0C, 32'h2, 4'hF);
    @(negedge clk);
    chk("w1c_irq", {31'b0, irq_o}, 32'd0);
    rdchk("w1c_status", 32'h0C, 32'd0);

    wr(32'h00, 32'h12, 4'hF);
    xfer(1'b1, 32'h04, 32'h55, 4'hF, 1'b1, 2'd1, 32'hAA, rd);
    rdchk("conf_same_acc1", 32'h14, 32'h55);
    wr(32'h14, 32'd0, 4'hF);
    rdchk("acc1_direct_clr", 32'h14, 32'd0);
    xfer(1'b1, 32'h04, 32'h55, 4'hF, 1'b1, 2'd0, 32'hAA, rd);
    rdchk("conf_diff_acc0", 32'h10, 32'hAA);
    rdchk("conf_diff_acc1", 32'h14, 32'h55);
    rdchk("load_status", 32'h0C, 32'd0);

    wr(32'h00, 32'hF0, 4'hF);
    wr(32'h04, 32'd9, 4'hF);
    rdchk("oor_result", 32'h08, 32'd0);
    chk("oor_accsel", acc_sel_o, 32'd0);
    rdchk("oor_ctrl", 32'h00, 32'hF0);
    rdchk("oor_acc0", 32'h10, 32'hAA);
    rdchk("oor_acc1", 32'h14, 32'h55);
    rdchk("oor_acc2", 32'h18, 32'd12);
    rdchk("oor_acc3", 32'h1C, 32'd0);
    wr(32'h00, 32'h20, 4'hF);
    wr(32'h04, 32'd3, 4'h3);
    rdchk("partsel_result", 32'h08, 32'd12);

    wr(32'h00, 32'h21, 4'hF);
    wr(32'h04, 32'd20, 4'hF);
    rdchk("sub_result", 32'h08, 32'hFFFF_FFF8);
    chk("sub_accsel", acc_sel_o, 32'hFFFF_FFF8);
    rdchk("sub_status", 32'h0C, 32'd0);
    wr(32'h00, 32'h23, 4'hF);
    wr(32'h04, 32'h1234, 4'hF);
    rdchk("clr_result", 32'h08, 32'd0);
    rdchk("operand_rd", 32'h04, 32'd0);
    rdchk("unmapped_rd", 32'h40, 32'd0);

    wr(32'h1C, 32'hFFFF_FF12, 4'h1);
    rdchk("bytewr_acc3", 32'h1C, 32'h12);

    wr(32'h00, 32'h32, 4'hF);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h04; wbs_dat_i = 32'h77; wbs_sel_i = 4'hF;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_ack0", {31'b0, wbs_ack_o}, 32'd0);
    @(negedge clk);
    chk("rstmid_ack1", {31'b0, wbs_ack_o}, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ack2", {31'b0, wbs_ack_o}, 32'd0);
    rdchk("rstmid_acc3", 32'h1C, 32'd0);
    rdchk("rstmid_acc0", 32'h10, 32'd0);
    rdchk("rstmid_ctrl", 32'h00, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
